// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: initiator side of the memReg register-file port with a hazard scoreboard and a write-back queue.
//  Optional feature macro: BYPASS_EN (a busy source is forwarded from a matching write-back queue entry).
//  Ports:
//   clk, rst                  clock and synchronous active-high reset
//   op_valid/op_ready         operand request handshake (op_rs1, op_rs2, op_rd, op_rd_we)
//   opd_valid, opd_a, opd_b   operand return, opd_valid pulses for one cycle
//   wb_valid/wb_ready         write-back handshake (wb_rd, wb_data)
//   reg_rd, reg_wr            memReg rd_allow / wr_allow
//   rf_rs1, rf_rs2, rf_rd     memReg addresses; rf_di write data; rf_d1/rf_d2 read data
//   sb_busy, wbq_count        scoreboard bits and write-back queue occupancy
module reg_access_ctrl #(
  parameter int REG_AW    = 4,
  parameter int DATA_W    = 32,
  parameter int WBQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [REG_AW-1:0]             op_rs1,
  input  logic [REG_AW-1:0]             op_rs2,
  input  logic [REG_AW-1:0]             op_rd,
  input  logic                          op_rd_we,
  output logic                          opd_valid,
  output logic [DATA_W-1:0]             opd_a,
  output logic [DATA_W-1:0]             opd_b,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [REG_AW-1:0]             wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          reg_rd,
  output logic                          reg_wr,
  output logic [REG_AW-1:0]             rf_rs1,
  output logic [REG_AW-1:0]             rf_rs2,
  output logic [REG_AW-1:0]             rf_rd,
  output logic [DATA_W-1:0]             rf_di,
  input  logic [DATA_W-1:0]             rf_d1,
  input  logic [DATA_W-1:0]             rf_d2,
  output logic [2**REG_AW-1:0]          sb_busy,
  output logic [$clog2(WBQ_DEPTH):0]    wbq_count
);
  localparam int NR = 2**REG_AW;
  localparam int PW = $clog2(WBQ_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_n;
  logic [REG_AW-1:0] q_rd [WBQ_DEPTH];
  logic [DATA_W-1:0] q_data [WBQ_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic hazard, accept, push, pop;
  logic [NR-1:0] sb_set, sb_clr;
  logic [DATA_W-1:0] cap_a, cap_b;
`ifdef BYPASS_EN
  logic hit_a, hit_b, byp_a_en, byp_b_en;
  logic [DATA_W-1:0] hit_a_val, hit_b_val, byp_a, byp_b;
  logic [PW-1:0] idx;
  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    hit_a_val = '0;
    hit_b_val = '0;
    idx = '0;
    for (int i = 0; i < WBQ_DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < wbq_count && q_rd[idx] == op_rs1) begin
        hit_a = 1'b1;
        hit_a_val = q_data[idx];
      end
      if (CW'(i) < wbq_count && q_rd[idx] == op_rs2) begin
        hit_b = 1'b1;
        hit_b_val = q_data[idx];
      end
    end
  end
  assign hazard = (sb_busy[op_rs1] & ~hit_a) | (sb_busy[op_rs2] & ~hit_b) | (op_rd_we & sb_busy[op_rd]);
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_a_en <= 1'b0;
      byp_b_en <= 1'b0;
      byp_a <= '0;
      byp_b <= '0;
    end else if (accept) begin
      byp_a_en <= sb_busy[op_rs1] & hit_a;
      byp_b_en <= sb_busy[op_rs2] & hit_b;
      byp_a <= hit_a_val;
      byp_b <= hit_b_val;
    end
  end
  assign cap_a = byp_a_en ? byp_a : rf_d1;
  assign cap_b = byp_b_en ? byp_b : rf_d2;
`else
  assign hazard = sb_busy[op_rs1] | sb_busy[op_rs2] | (op_rd_we & sb_busy[op_rd]);
  assign cap_a = rf_d1;
  assign cap_b = rf_d2;
`endif
  always_comb begin
    op_ready = (state == IDLE) & ~hazard;
    reg_rd = state == READ;
    state_n = (op_valid & op_ready) ? READ : IDLE;
  end
  assign accept = op_valid & op_ready;
  assign wb_ready = wbq_count != CW'(WBQ_DEPTH);
  assign reg_wr = wbq_count != '0;
  assign pop = reg_wr;
  assign push = wb_valid & wb_ready;
  assign rf_rd = q_rd[rptr];
  assign rf_di = q_data[rptr];
  // Clear precedes set so a same-edge claim of the popped register stays busy.
  assign sb_clr = pop ? NR'(1) << rf_rd : '0;
  assign sb_set = (accept & op_rd_we) ? NR'(1) << op_rd : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opd_valid <= 1'b0;
      opd_a <= '0;
      opd_b <= '0;
      rf_rs1 <= '0;
      rf_rs2 <= '0;
      sb_busy <= '0;
      wptr <= '0;
      rptr <= '0;
      wbq_count <= '0;
    end else begin
      state <= state_n;
      opd_valid <= state == READ;
      if (state == READ) begin
        opd_a <= cap_a;
        opd_b <= cap_b;
      end
      if (accept) begin
        rf_rs1 <= op_rs1;
        rf_rs2 <= op_rs2;
      end
      sb_busy <= (sb_busy & ~sb_clr) | sb_set;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      wbq_count <= wbq_count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr] <= wb_rd;
      q_data[wptr] <= wb_data;
    end
  end
endmodule
